// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and saturating stall/bubble performance counters.
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_flush,
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic en);
    if (en && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
    return c;
  endfunction

  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic              in_xfer, out_xfer;

  // o_ready comes straight from a flop, so upstream never sees i_ready combinationally.
  assign o_ready  = ~skid_vld_q;
  assign o_valid  = main_vld_q;
  assign o_data   = main_data_q;
  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = main_vld_q & i_ready;

  assign o_stall_cnt  = stall_q;
  assign o_bubble_cnt = bubble_q;

  always_comb begin
    main_vld_d  = main_vld_q;
    skid_vld_d  = skid_vld_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (i_flush) begin
      main_vld_d  = 1'b0;
      skid_vld_d  = 1'b0;
      main_data_d = '0;
      skid_data_d = '0;
    end else if (!main_vld_q) begin
      if (in_xfer) begin
        main_vld_d  = 1'b1;
        main_data_d = i_data;
      end
    end else if (!skid_vld_q) begin
      if (in_xfer && out_xfer) begin
        main_data_d = i_data;
      end else if (in_xfer) begin
        skid_vld_d  = 1'b1;
        skid_data_d = i_data;
      end else if (out_xfer) begin
        // main_data_q keeps the last delivered bundle while idle
        main_vld_d = 1'b0;
      end
    end else if (out_xfer) begin
      main_data_d = skid_data_q;
      skid_vld_d  = 1'b0;
    end
  end

  always_comb begin
    stall_d  = sat_inc(stall_q, main_vld_q & ~i_ready);
    bubble_d = sat_inc(bubble_q, ~main_vld_q);
    if (i_cnt_clr) begin
      stall_d  = '0;
      bubble_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
      bubble_q    <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
    end
  end

endmodule
